// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner, the keypad matrix and the game logic.
// Latency: none, wires only.
// Backpressure: none; key/keypad_pressed are levels and key_strobe is a single-cycle pulse.
interface keypad_scanner_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] key;
    logic       keypad_pressed;
    logic       key_strobe;

    // Scanner side: samples columns, drives rows and the key report.
    modport master (
        input  col_n,
        output row_n,
        output key,
        output keypad_pressed,
        output key_strobe
    );

    // Keypad/consumer side.
    modport slave (
        output col_n,
        input  row_n,
        input  key,
        input  keypad_pressed,
        input  key_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with ghost rejection and press/release debounce.
// Latency: press/release accepted DEBOUNCE_SCANS full scans (4*SCAN_CYCLES clocks each) after a clean edge.
// Backpressure: none; the consumer samples the keypad_pressed level or the one-cycle key_strobe.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    typedef enum logic [1:0] {RELEASED, DEB_PRESS, PRESSED} state_t;

    logic [3:0]    col_meta_q, col_sync_q;
    logic [SW-1:0] cyc_q;
    logic [1:0]    row_q;
    logic [1:0]    hits_q;      // low columns seen so far this scan, saturates at 2
    logic [3:0]    code_q;      // code of the single hit seen so far this scan
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d;
    logic [3:0]    cand_q, cand_d, key_q, key_d;
    logic          pressed_q, pressed_d, strobe_q, strobe_d;

    logic          row_end, scan_end, scan_single;
    logic [3:0]    col_low, row_code, tot_code;
    logic [2:0]    row_cnt, hit_sum;
    logic [1:0]    tot_hits;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;   4'h2: key_code = 4'd3;   4'h3: key_code = 4'd10;
            4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;   4'h6: key_code = 4'd6;   4'h7: key_code = 4'd11;
            4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;   4'hA: key_code = 4'd9;   4'hB: key_code = 4'd12;
            4'hC: key_code = 4'd14;  4'hD: key_code = 4'd0;   4'hE: key_code = 4'd15;  default: key_code = 4'd13;
        endcase
    endfunction

    assign row_end  = (cyc_q == SW'(SCAN_CYCLES - 1));
    assign scan_end = row_end && (row_q == 2'd3);
    assign col_low  = ~col_sync_q;

    // Fold the current row's sample into the running scan result.
    always_comb begin
        row_cnt  = {2'b00, col_low[0]} + {2'b00, col_low[1]} + {2'b00, col_low[2]} + {2'b00, col_low[3]};
        row_code = 4'd0;
        for (int c = 0; c < 4; c++) begin
            if (col_low[c]) row_code = key_code(row_q, 2'(c));
        end
        hit_sum  = {1'b0, hits_q} + row_cnt;
        tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code = (hits_q == 2'd0) ? row_code : code_q;
    end

    assign scan_single = (tot_hits == 2'd1);

    // Two-flop synchronizer: col_n is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= kp.col_n;
            col_sync_q <= col_meta_q;
        end
    end

    // Row window timing and per-scan hit accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            row_q  <= 2'd0;
            hits_q <= 2'd0;
            code_q <= 4'd0;
        end else if (row_end) begin
            cyc_q <= '0;
            row_q <= row_q + 2'd1;
            if (scan_end) begin
                hits_q <= 2'd0;
                code_q <= 4'd0;
            end else begin
                hits_q <= tot_hits;
                code_q <= tot_code;
            end
        end else begin
            cyc_q <= cyc_q + SW'(1);
        end
    end

    // Debounce FSM state and report registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            rel_q     <= '0;
            cand_q    <= 4'd0;
            key_q     <= 4'd0;
            pressed_q <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            cand_q    <= cand_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
            strobe_q  <= strobe_d;
        end
    end

    // Debounce transitions, taken only at scan end; MULTI counts as no key.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        cand_d    = cand_q;
        key_d     = key_q;
        pressed_d = pressed_q;
        strobe_d  = 1'b0;
        if (scan_end) begin
            case (state_q)
                RELEASED: begin
                    if (scan_single) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            key_d     = tot_code;
                            pressed_d = 1'b1;
                            strobe_d  = 1'b1;
                            rel_d     = '0;
                            state_d   = PRESSED;
                        end else begin
                            cand_d  = tot_code;
                            cnt_d   = CW'(1);
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!scan_single) begin
                        cnt_d   = '0;
                        state_d = RELEASED;
                    end else if (tot_code != cand_q) begin
                        cand_d = tot_code;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                        key_d     = cand_q;
                        pressed_d = 1'b1;
                        strobe_d  = 1'b1;
                        rel_d     = '0;
                        cnt_d     = '0;
                        state_d   = PRESSED;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PRESSED: begin
                    if (scan_single && (tot_code == key_q)) begin
                        rel_d = '0;
                    end else if (rel_q == CW'(DEBOUNCE_SCANS - 1)) begin
                        rel_d     = '0;
                        pressed_d = 1'b0;
                        state_d   = RELEASED;
                    end else begin
                        rel_d = rel_q + CW'(1);
                    end
                end
                default: state_d = RELEASED;
            endcase
        end
    end

    assign kp.row_n          = ~(4'b0001 << row_q);
    assign kp.key            = {1'b0, key_q};
    assign kp.keypad_pressed = pressed_q;
    assign kp.key_strobe     = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: ideal keypad matrix driven per scan, scan-history reference model.
// Latency: checks outputs at every scan boundary (16 clocks with SCAN_CYCLES=4).
// Backpressure: none; strobes are counted per scan.
module tb_keypad_scanner;
    localparam int SCAN = 4;
    localparam int DEB  = 3;

    logic clk;
    logic rst;
    logic [15:0] held;     // bit k set = key with code k is physically held

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_SCANS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif.master)
    );

    int code_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: full history of scan results since the last reset.
    int hist[$];        // -1 none, -2 multi, else single key code
    int since_m;        // first history index evaluated in the current press/release state
    bit pressed_m;
    int key_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        kif.col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kif.row_n[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (held[code_map[r*4 + c]]) kif.col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        since_m   = 0;
        pressed_m = 1'b0;
        key_m     = 0;
    endtask

    // Apply the debounce rules to the history after a new scan result; returns 1 on an accepted press.
    task automatic model_scan(input logic [15:0] mask, output bit exp_strobe);
        int res, k, n;
        bit all_ok;
        n = $countones(mask);
        res = -1;
        if (n > 1) res = -2;
        else if (n == 1) begin
            for (int i = 0; i < 16; i++) if (mask[i]) res = i;
        end
        hist.push_back(res);
        k = hist.size() - 1;
        exp_strobe = 1'b0;
        if (k - since_m + 1 >= DEB) begin
            all_ok = 1'b1;
            for (int i = k - DEB + 1; i <= k; i++) begin
                if (!pressed_m && (res < 0 || hist[i] != res)) all_ok = 1'b0;
                if (pressed_m && hist[i] == key_m) all_ok = 1'b0;
            end
            if (all_ok) begin
                if (!pressed_m) begin
                    key_m      = res;
                    exp_strobe = 1'b1;
                end
                pressed_m = !pressed_m;
                since_m   = k + 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_pressed", kif.keypad_pressed, 0);
        check_eq("rst_key", kif.key, 0);
        check_eq("rst_strobe", kif.key_strobe, 0);
        check_eq("rst_row_n", kif.row_n, 4'b1110);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One full scan with a fixed held-key set, then compare against the model.
    task automatic run_scan(input logic [15:0] mask);
        int strobes;
        bit exp_strobe;
        logic [3:0] exp_row;
        strobes = 0;
        held = mask;
        for (int j = 1; j <= 4*SCAN; j++) begin
            @(posedge clk); #1;
            exp_row = ~(4'b0001 << ((j / SCAN) % 4));
            check_eq("row_n", kif.row_n, exp_row);
            if (kif.key_strobe === 1'b1) strobes++;
        end
        model_scan(mask, exp_strobe);
        check_eq("keypad_pressed", kif.keypad_pressed, pressed_m);
        check_eq("key", kif.key, key_m);
        check_eq("strobe_count", strobes, exp_strobe);
    endtask

    function automatic logic [15:0] bit_of(input int code);
        logic [15:0] m;
        m = '0;
        m[code] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [15:0] cur;
        held = '0;
        rst  = 1'b1;
        model_reset();
        do_reset();

        // Clean press of key 2, hold, release.
        repeat (4) run_scan(bit_of(2));
        repeat (3) run_scan('0);

        // Bounce on key 6: one scan on, one scan off.
        repeat (6) begin
            run_scan(bit_of(6));
            run_scan('0);
        end

        // Ghost: 2 and 8 together, then 8 alone, then release.
        repeat (4) run_scan(bit_of(2) | bit_of(8));
        repeat (4) run_scan(bit_of(8));
        repeat (4) run_scan('0);

        // Roll from a held key to a different one.
        repeat (3) run_scan(bit_of(5));
        repeat (6) run_scan(bit_of(9));
        repeat (3) run_scan('0);

        // Reset while a key is held and accepted.
        repeat (3) run_scan(bit_of(0));
        do_reset();
        repeat (4) run_scan(bit_of(0));
        repeat (3) run_scan('0);

        // Randomized scans.
        cur = '0;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ;
                4, 5:       cur = '0;
                6, 7, 8:    cur = bit_of($urandom_range(0, 15));
                default:    cur = bit_of($urandom_range(0, 15)) | bit_of($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 39) == 0) do_reset();
            run_scan(cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad and debounces it. Produces the `key` / `keypad_pressed` pair consumed by the game logic, which reads key codes 2 (fly), 6 (jump) and 8 (crouch).
- Sits between the board keypad pins and the game/state-machine blocks.
- Drives rows active-low one at a time, samples active-low columns, rejects multi-key presses, and requires stable readings over several full scans before reporting a press or release.

Parameters:
- SCAN_CYCLES, 1000: clocks each row stays driven before its columns are sampled (minimum 4).
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release (minimum 1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- col_n  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk
- row_n  output  4  keypad row drive, one-hot active-low
- key  output  5  code of the accepted key; bit 4 always 0
- keypad_pressed  output  1  high while the accepted key is held (debounced level)
- key_strobe  output  1  one-cycle pulse when a new press is accepted

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - row_n=4'b1110 (row 0), row counter 0, cycle counter 0.
  - key=5'd0, keypad_pressed=0, key_strobe=0.
  - FSM in RELEASED; all debounce counters 0.
  - rst mid-press drops keypad_pressed in the same edge.
- Synchronizer: col_n passes through a 2-flop synchronizer before any use.
- Scan timing:
  - Row r is driven for SCAN_CYCLES clocks, then row_n advances: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - The synchronized columns are sampled on the last clock of each row window.
  - One full scan = 4*SCAN_CYCLES clocks; the scan ends when row 3's window closes.
- Key code map (row r, column c, c=0 is col_n[0]):
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14(*), 0, 15(#), 13
- Scan result, evaluated at scan end:
  - NONE if no low column was sampled in any row.
  - SINGLE(code) if exactly one low bit was sampled across all four rows.
  - MULTI if two or more were sampled.
  - MULTI is treated as "no valid key" (ghost rejection).
- FSM, all transitions at scan end only:
  - RELEASED:
    - SINGLE(c): cand<=c, cnt<=1, go to DEB_PRESS. If DEBOUNCE_SCANS==1, go directly to the accept action.
    - Otherwise stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept: key<=cand, keypad_pressed<=1, key_strobe=1 for exactly that clock, go to PRESSED with rel_cnt<=0.
    - SINGLE(other): restart with cand<=other, cnt<=1.
    - NONE or MULTI: go to RELEASED.
  - PRESSED:
    - SINGLE(key): rel_cnt<=0.
    - Anything else (NONE, MULTI, different key): rel_cnt++. When rel_cnt reaches DEBOUNCE_SCANS, keypad_pressed<=0 and go to RELEASED.
    - A different key pressed while holding is never reported until a full release is accepted.
- key holds its last accepted value after release. It changes only on accept or reset.
- key_strobe never asserts for a key hold or a repeat; at most one pulse per accepted press.
- Press latency, clean press starting at a scan boundary: DEBOUNCE_SCANS full scans. Release latency is the same.
- Counters saturate at DEBOUNCE_SCANS and never wrap.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, so one scan = 16 clocks):
- Reset: hold rst 2 cycles -> row_n=4'b1110, key=0, keypad_pressed=0, key_strobe=0. row_n steps to 4'b1101 exactly 4 clocks after rst deasserts.
- Clean press of key 2: col_n[1] low whenever row_n=4'b1110, from a scan boundary -> after 3 full scans (48 clocks), key=5'd2, keypad_pressed=1, key_strobe high exactly 1 cycle.
- Bounce: press key 6 for 1 scan, release 1 scan, repeated 6 times -> keypad_pressed stays 0 and key_strobe never pulses.
- Ghost rejection: keys 2 and 8 held together from RELEASED -> no accept. Then release 2 while keeping 8 -> key=5'd8 accepted 3 scans later.
- Release: after accepting key 8, release -> keypad_pressed falls after 3 full scans; key stays 5'd8; no strobe on release.
- Reset mid-press: assert rst while keypad_pressed=1 and the key is still held -> next edge gives keypad_pressed=0, key=0. The still-held key is re-accepted after 3 scans with one key_strobe.
